// File: rtl/bfp16_add_arbiter.sv
// rtl/bfp16_add_arbiter.sv - round-robin arbiter sharing one BFP16 adder across requesters
//
// bfp16_add: combinational BFP16 adder. The operand sits in the upper half
// of a 32-bit container (sign 31, exponent 30:23, mantissa 22:16). The lower
// half is ignored on input and zero on output. Subnormals flush to zero and
// rounding is round-to-nearest-even.
module bfp16_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  logic        w_swap;
  logic [31:0] w_x;        // larger magnitude operand
  logic [31:0] w_y;        // smaller magnitude operand
  logic [7:0]  w_ex, w_ey, w_d;
  logic [7:0]  w_sx, w_sy;
  logic        w_nan_x, w_nan_y, w_inf_x, w_inf_y, w_sub;
  logic [10:0] w_xe, w_ye, w_ya, w_mask;
  logic [11:0] w_sum;
  logic [3:0]  w_pos, w_lz;
  logic [10:0] w_norm;
  logic [9:0]  w_exp, w_exp2;
  logic        w_rup;
  logic [8:0]  w_rsig;
  logic [6:0]  w_man;
  logic        w_unused;

  assign w_unused = ^{i_a[15:0], i_b[15:0]};

  // Order operands by magnitude so alignment always shifts y right
  always_comb begin
    w_swap = i_b[30:16] > i_a[30:16];
    w_x    = w_swap ? i_b : i_a;
    w_y    = w_swap ? i_a : i_b;
  end

  // Align, add/subtract, normalise, round and classify the result
  always_comb begin
    w_ex    = w_x[30:23];
    w_ey    = w_y[30:23];
    w_sx    = (w_ex != 8'd0) ? {1'b1, w_x[22:16]} : 8'd0;
    w_sy    = (w_ey != 8'd0) ? {1'b1, w_y[22:16]} : 8'd0;
    w_nan_x = (w_ex == 8'hFF) && (w_x[22:16] != 7'd0);
    w_nan_y = (w_ey == 8'hFF) && (w_y[22:16] != 7'd0);
    w_inf_x = (w_ex == 8'hFF) && (w_x[22:16] == 7'd0);
    w_inf_y = (w_ey == 8'hFF) && (w_y[22:16] == 7'd0);
    w_sub   = w_x[31] ^ w_y[31];
    w_d     = w_ex - w_ey;
    // three extra bits below the significand: guard, round, sticky
    w_xe    = {w_sx, 3'b000};
    w_ye    = {w_sy, 3'b000};
    w_mask  = ~(11'h7FF << w_d);
    if (w_d >= 8'd11) begin
      w_ya = {10'd0, |w_sy};
    end else begin
      w_ya = (w_ye >> w_d) | {10'd0, |(w_ye & w_mask)};
    end
    w_sum = w_sub ? ({1'b0, w_xe} - {1'b0, w_ya}) : ({1'b0, w_xe} + {1'b0, w_ya});

    w_pos = 4'd0;
    for (int i = 0; i < 11; i++) begin
      if (w_sum[i]) w_pos = 4'(i);
    end
    w_lz = 4'd10 - w_pos;
    if (w_sum[11]) begin
      w_norm = {w_sum[11:2], w_sum[1] | w_sum[0]};
      w_exp  = {2'b00, w_ex} + 10'd1;
    end else begin
      w_norm = w_sum[10:0] << w_lz;
      w_exp  = {2'b00, w_ex} - {6'd0, w_lz};
    end

    w_rup  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rsig = {1'b0, w_norm[10:3]} + {8'd0, w_rup};
    if (w_rsig[8]) begin
      w_exp2 = w_exp + 10'd1;
      w_man  = w_rsig[7:1];
    end else begin
      w_exp2 = w_exp;
      w_man  = w_rsig[6:0];
    end

    if (w_nan_x || w_nan_y || (w_inf_x && w_inf_y && w_sub)) begin
      o_sum = 32'h7FC0_0000;
    end else if (w_inf_x) begin
      o_sum = {w_x[31], 8'hFF, 23'd0};
    end else if (w_sum == 12'd0) begin
      o_sum = 32'd0;
    end else if (w_exp[9] || (w_exp == 10'd0)) begin
      o_sum = {w_x[31], 31'd0};
    end else if (w_exp2 >= 10'd255) begin
      o_sum = {w_x[31], 8'hFF, 23'd0};
    end else begin
      o_sum = {w_x[31], w_exp2[7:0], w_man, 16'h0000};
    end
  end
endmodule

// bfp16_add_arbiter: round-robin grant into operand stage S1, shared adder,
// result stage S2 with valid/ready output tagged by requester index.
module bfp16_add_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 32,
  parameter int SIZE_ID   = $clog2(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data_a,
  input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data_b,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic [SIZE_DATA-1:0]         o_res_data,
  output logic [SIZE_ID-1:0]           o_res_id,
  output logic                         o_busy
);
  logic                 r_s1_valid;
  logic [SIZE_DATA-1:0] r_s1_a, r_s1_b;
  logic [SIZE_ID-1:0]   r_s1_id;
  logic                 r_s2_valid;
  logic [SIZE_DATA-1:0] r_s2_data;
  logic [SIZE_ID-1:0]   r_s2_id;
  logic [SIZE_ID-1:0]   r_last;

  logic                 w_s2_en, w_s1_free, w_grant, w_cand_valid;
  logic [SIZE_ID-1:0]   w_cand;
  logic [SIZE_DATA-1:0] w_sel_a, w_sel_b, w_sum;

  assign w_s2_en   = r_s1_valid & (~r_s2_valid | i_res_ready);
  assign w_s1_free = ~r_s1_valid | w_s2_en;
  // ready is held low while reset is asserted even though S1 reads as free
  assign w_grant   = i_rst_n & w_s1_free & w_cand_valid;

  // Candidate: lowest valid index above last, else lowest valid index (wrap)
  always_comb begin
    w_cand_valid = 1'b0;
    w_cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        w_cand_valid = 1'b1;
        w_cand       = SIZE_ID'(k);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[k] && (SIZE_ID'(k) > r_last)) w_cand = SIZE_ID'(k);
    end
  end

  // One-hot ready and operand mux for the granted requester
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_req_ready[k] = w_grant && (w_cand == SIZE_ID'(k));
      if (w_cand == SIZE_ID'(k)) begin
        w_sel_a = i_req_data_a[k*SIZE_DATA +: SIZE_DATA];
        w_sel_b = i_req_data_b[k*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  bfp16_add u_add (
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .o_sum (w_sum)
  );

  // Operand stage and round-robin pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_id    <= '0;
      r_last     <= SIZE_ID'(NUM_REQ - 1);
    end else if (w_s1_free) begin
      r_s1_valid <= w_grant;
      if (w_grant) begin
        r_s1_a  <= w_sel_a;
        r_s1_b  <= w_sel_b;
        r_s1_id <= w_cand;
        r_last  <= w_cand;
      end
    end
  end

  // Result stage: load from adder when S1 advances, else drain on ready
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_id    <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= 1'b1;
      r_s2_data  <= w_sum;
      r_s2_id    <= r_s1_id;
    end else if (i_res_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign o_res_valid = r_s2_valid;
  assign o_res_data  = r_s2_data;
  assign o_res_id    = r_s2_id;
  assign o_busy      = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_bfp16_add_arbiter.sv
// tb/tb_bfp16_add_arbiter.sv - self-checking bench for bfp16_add_arbiter
module tb_bfp16_add_arbiter;
  localparam int NUM = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NUM-1:0]  req_valid;
  logic [NUM-1:0]  req_ready;
  logic [NUM*32-1:0] data_a, data_b;
  logic            res_valid, res_ready;
  logic [31:0]     res_data;
  logic [1:0]      res_id;
  logic            busy;

  always #5 clk = ~clk;

  bfp16_add_arbiter #(.NUM_REQ(NUM)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_data_a (data_a),
    .i_req_data_b (data_b),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_data   (res_data),
    .o_res_id     (res_id),
    .o_busy       (busy)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    int          age;
  } ent_t;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  int   grants[$];
  int   last;
  bit   v[NUM];
  int   av[NUM];
  int   bv[NUM];
  bit   stream[NUM];
  int   pct;

  // Exact BFP16 encoding of a small integer (|v| < 256 fits the 8-bit significand)
  function automatic logic [31:0] to_bf(int val);
    int m;
    int e;
    logic s;
    logic [7:0] ex;
    logic [6:0] mn;
    if (val == 0) return 32'd0;
    s = (val < 0);
    m = s ? -val : val;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    ex = 8'(127 + e);
    mn = 7'((m << (7 - e)) & 127);
    return {s, ex, mn, 16'h0000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NUM; k++) begin
      req_valid[k]        = v[k];
      data_a[k*32 +: 32]  = to_bf(av[k]);
      data_b[k*32 +: 32]  = to_bf(bv[k]);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < NUM; k++) begin
      if (!v[k] && stream[k] && ($urandom_range(99) < pct)) begin
        v[k]  = 1'b1;
        av[k] = int'($urandom_range(254)) - 127;
        bv[k] = int'($urandom_range(254)) - 127;
      end
    end
  endtask

  task automatic set_req(input int k, input int a, input int b);
    v[k]  = 1'b1;
    av[k] = a;
    bv[k] = b;
  endtask

  task automatic model_reset();
    q.delete();
    last = NUM - 1;
    for (int k = 0; k < NUM; k++) begin
      v[k] = 1'b0;
      stream[k] = 1'b0;
    end
  endtask

  // One clock: predict from the model, compare before the edge, then advance the model
  task automatic cycle();
    bit   found, vis, ohs, acc;
    int   cand;
    logic [NUM-1:0] er;
    ent_t ent;
    refresh();
    drive();
    #1;
    vis = (q.size() > 0) && (q[0].age >= 1);
    ohs = vis && res_ready;
    found = 1'b0;
    cand = 0;
    for (int j = 1; j <= NUM; j++) begin
      int k;
      k = (last + j) % NUM;
      if (!found && v[k]) begin
        found = 1'b1;
        cand = k;
      end
    end
    acc = found && ((q.size() - int'(ohs)) < 2);
    er = acc ? NUM'(1 << cand) : '0;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("res_valid", 32'(res_valid), 32'(vis));
    chk("busy", 32'(busy), 32'(q.size() > 0));
    if (vis) begin
      chk("res_data", res_data, q[0].data);
      chk("res_id", 32'(res_id), 32'(q[0].id));
    end
    ent.id = cand;
    ent.data = to_bf(av[cand] + bv[cand]);
    ent.age = 0;
    @(posedge clk);
    if (ohs) void'(q.pop_front());
    foreach (q[i]) q[i].age++;
    if (acc) begin
      q.push_back(ent);
      last = cand;
      v[cand] = 1'b0;
      grants.push_back(cand);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < NUM; k++) stream[k] = 1'b0;
    res_ready = 1'b1;
    repeat (8) cycle();
    #1;
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    res_ready = 1'b1;
    pct = 100;
    model_reset();
    for (int k = 0; k < NUM; k++) set_req(k, 1, 1);
    drive();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    model_reset();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single request: 1.0 + 2.0 from requester 0, result one edge after accept
    set_req(0, 1, 2);
    cycle();
    cycle();
    #1;
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_data", res_data, 32'h4040_0000);
    chk("single_id", 32'(res_id), 32'd0);
    drain();

    // round robin with all requesters streaming
    grants.delete();
    for (int k = 0; k < NUM; k++) stream[k] = 1'b1;
    pct = 100;
    res_ready = 1'b1;
    repeat (12) cycle();
    chk("rr_count", 32'(grants.size()), 32'd12);
    chk("rr_first", 32'(grants[0]), 32'd1);
    for (int i = 1; i < 12; i++) chk("rr_order", 32'(grants[i]), 32'((grants[i-1] + 1) % NUM));
    drain();

    // backpressure with requesters 1 and 2 streaming
    stream[1] = 1'b1;
    stream[2] = 1'b1;
    repeat (4) cycle();
    res_ready = 1'b0;
    cycle();
    cycle();
    refresh();
    drive();
    #1;
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    cycle();
    res_ready = 1'b1;
    repeat (4) cycle();
    drain();

    // zero operand passthrough from requester 3
    set_req(3, -3, 0);
    cycle();
    cycle();
    #1;
    chk("zero_valid", 32'(res_valid), 32'd1);
    chk("zero_data", res_data, 32'hC040_0000);
    chk("zero_id", 32'(res_id), 32'd3);
    drain();

    // skip invalid requesters: last=1, only requester 0 valid
    set_req(1, 5, 6);
    cycle();
    set_req(0, 7, 8);
    drive();
    #1;
    chk("wrap_grant", 32'(req_ready), 32'd1);
    cycle();
    drain();

    // randomized traffic and backpressure
    for (int k = 0; k < NUM; k++) stream[k] = 1'b1;
    pct = 50;
    repeat (300) begin
      res_ready = ($urandom_range(99) < 60);
      cycle();
    end
    pct = 100;
    drain();

    // reset mid-operation with both stages full
    for (int k = 0; k < NUM; k++) stream[k] = 1'b1;
    res_ready = 1'b0;
    repeat (3) cycle();
    #1;
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_valid", 32'(res_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    model_reset();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    set_req(0, 9, 10);
    set_req(2, 11, 12);
    drive();
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'd1);
    cycle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bfp16_add_arbiter.md
# bfp16_add_arbiter

Shares one combinational BFP16 adder (the 32-bit-container BFP16 add unit, mantissa in bits [22:16]) between `NUM_REQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one pair per cycle into a two-stage pipeline: an operand register, then the shared adder, then a result register. The result leaves through a valid/ready output tagged with the requester ID. The block sits between the sort/compare front-ends and the shared arithmetic, and is the only instantiation point for the adder in the cluster.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `SIZE_DATA`, 32: operand/result container width; fixed at 32.
- `SIZE_ID`, `$clog2(NUM_REQ)`: width of the requester tag.

Ports:
- `i_clk`  in  1  single clock; all state on rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  NUM_REQ  per-requester operand pair valid.
- `o_req_ready`  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- `i_req_data_a`  in  NUM_REQ*32  operand A; requester k uses bits [32k+31:32k].
- `i_req_data_b`  in  NUM_REQ*32  operand B; same packing.
- `o_res_valid`  out  1  result valid.
- `i_res_ready`  in  1  downstream accept.
- `o_res_data`  out  32  sum A+B from the adder, registered.
- `o_res_id`  out  SIZE_ID  index of the requester that issued the result.
- `o_busy`  out  1  either pipeline stage holds a valid entry.

## Operation
- **S1 (operand stage):** registers `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
- **S2 (result stage):** registers `s2_valid`, `s2_data`, `s2_id`. These drive `o_res_valid`, `o_res_data` and `o_res_id` directly.
- **Adder input:** the adder is purely combinational between S1 and S2 and sees only `s1_a` and `s1_b`.
- **Advance rules:**
  - `s2_en = s1_valid & (~s2_valid | i_res_ready)`.
  - `s1_free = ~s1_valid | s2_en`.
  - On a rising edge: if `s2_en`, S2 loads the adder output and `s1_id`. Otherwise, if `i_res_ready` is high, `s2_valid` clears.
- **Arbitration (round-robin):**
  - `last` pointer, SIZE_ID bits.
  - Search order is `last+1, last+2, …`, wrapping modulo NUM_REQ.
  - The first requester k with `i_req_valid[k]` is the candidate.
  - `o_req_ready[k] = s1_free & candidate==k`.
  - On a handshake: S1 loads requester k's operands with `s1_id=k`, and `last←k`.
  - If no requester is valid or `s1_free` is low, `last` is held.
- **Ready/valid dependency:**
  - `o_req_ready` may depend combinationally on `i_req_valid` and `i_res_ready`.
  - Requesters must not make valid depend on ready.
  - Once asserted, a request's valid and data stay stable until accepted.
- **No loss, no duplication:** every accepted pair produces exactly one result. Results leave in acceptance order.
- **Data handling:** data is passed through unmodified. Zero, Inf and NaN handling is entirely the adder's.
- **Output:** `o_busy = s1_valid | s2_valid`.

## Timing
- **Reset values** (asynchronous, immediate on `i_rst_n` low):
  - `s1_valid=0`, `s2_valid=0`, so `o_res_valid=0` and `o_busy=0`.
  - `o_res_data=0`, `o_res_id=0`, `o_req_ready` all 0.
  - `last=NUM_REQ-1`, so requester 0 has first priority.
- **Reset mid-operation:** in-flight entries are discarded with no output.
  - The first grant after release goes to the lowest-indexed valid requester.
- **Latency:** a pair accepted at edge N appears on `o_res_valid` after edge N+1, when S2 is empty.
- **Throughput:** 1 result/cycle with `i_res_ready` held high.
- **Backpressure:** with `i_res_ready` low and S2 full, S2 holds.
  - S1 fills once, then all `o_req_ready` drop until S2 drains.
  - Capacity is 2 entries.
- **Simultaneous drain and fill:** S2 draining while S1 advances and a new grant lands in S1 is legal in the same edge; this is full rate.
- **Single requester:** a lone valid requester is granted every cycle, regardless of `last`.

## Test plan
- **Single request, latency:**
  - Stimulus: requester 0 presents A=0x3F800000 (1.0), B=0x40000000 (2.0); handshake at edge 0.
  - Response: `o_res_valid` is high after edge 1 with `o_res_data`=0x40400000 (3.0) and `o_res_id`=0.
- **Round-robin fairness:**
  - Stimulus: all 4 requesters continuously valid, `i_res_ready`=1.
  - Response: grants go 0,1,2,3,0,1…, one per cycle. `o_res_id` follows the same sequence two cycles later, with no gaps.
- **Backpressure:**
  - Stimulus: requesters 1 and 2 streaming; `i_res_ready` low for 3 cycles mid-stream.
  - Response: S2 value is stable, one more accept fills S1, then `o_req_ready`=0. After release, the remaining results come out in order with no loss or duplication. A scoreboard checks each sum per ID.
- **Zero operand passthrough:**
  - Stimulus: requester 3 presents A=0xC0400000 (-3.0), B=0x00000000.
  - Response: `o_res_data`=0xC0400000 and `o_res_id`=3.
- **Reset mid-operation:**
  - Stimulus: both stages full, `i_res_ready`=0, then `i_rst_n` pulled low between edges.
  - Response: `o_res_valid` and `o_busy` drop immediately. After release with requesters 0 and 2 valid, the first grant is to 0.
- **Skip invalid requesters:**
  - Stimulus: `last`=1, only requester 0 valid.
  - Response: requester 0 is granted via wrap-around in the same cycle.
